cpu_mem_wb_stage: RTL
=====================

Name: cpu_mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back logic of the 5-stage pipelined CPU.
- Captures the MEM-stage result, aligns and extends load data, and selects the write-back source.
- Drives the register file write port (we/waddr/wdata) directly.
- Provides the same bus to the forwarding unit as the WB-stage bypass source.

Parameters:
- DW, 32, datapath width
- AW_RF, 32, width of register file address bus (5-bit index, zero-extended)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset: one clock; reset is asynchronous and active-low
- stall  in  1  hold MEM/WB register contents
- flush  in  1  insert bubble into WB
- mem_valid  in  1  MEM stage holds a real instruction
- mem_we  in  1  instruction writes a GPR
- mem_rd  in  5  destination register index
- mem_wb_sel  in  2  source: 00 ALU, 01 load, 10 link (pc+8), 11 reserved (treated as ALU)
- mem_ld_type  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw
- mem_alu_res  in  DW  ALU result / effective address
- mem_rdata  in  DW  raw data-memory word
- mem_pc  in  DW  instruction PC
- wb_valid  out  1  WB holds a real instruction
- wb_we  out  1  regfile write enable
- wb_waddr  out  AW_RF  regfile write address
- wb_wdata  out  DW  regfile write data
- retire_cnt  out  32  retired-instruction count (feature only)

Behaviour:
- Reset (rst=0, asynchronous): all captured fields cleared. Outputs: wb_valid=0, wb_we=0, wb_waddr=0, wb_wdata=0, retire_cnt=0.
- Latency: one cycle. Inputs sampled at posedge N drive wb_* after posedge N, combinationally from registered fields.
- Priority per posedge: flush > stall > load.
  - flush=1: valid and we are cleared; other fields are don't-care but retained.
  - stall=1 (no flush): all fields hold; outputs unchanged.
  - Otherwise: all mem_* fields are captured.
- Write enable: wb_we = valid & we & (rd != 0). $0 is never written, even though the regfile also guards it.
- Write address: wb_waddr = {27'b0, rd}.
- Load alignment (little-endian, byte offset = alu_res[1:0]):
  - lb/lbu: select the byte at the offset; sign-extend (lb) or zero-extend (lbu).
  - lh/lhu: select halfword alu_res[1] (0 = bits 15:0, 1 = bits 31:16); sign- or zero-extend. alu_res[0] is ignored.
  - lw: word passed unaltered; offset ignored.
- Write-back select:
  - 00/11: alu_res
  - 01: aligned load data
  - 10: pc+8, modulo 2^32 (pc=0xFFFFFFFC gives 0x00000004)
- Reset released mid-stream: the first capture occurs on the first posedge with rst=1; no spurious write before it.
- Stall and flush asserted together: bubble (flush wins).

Optional Feature:
- Macro: CPU_RETIRE_CNT_EN
- Defined: 32-bit retire_cnt increments on each posedge where wb_valid=1 and stall=0. It wraps 0xFFFFFFFF -> 0 and is cleared by reset.
- Not defined: retire_cnt is tied to 0 and no counter flops exist. The port list is unchanged.

Decomposition:
- cpu_pkg holds:
  - LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU codes
  - WB_SEL_ALU/WB_SEL_LOAD/WB_SEL_LINK codes
  - the link offset constant (8)
- One combinational sub-module, cpu_load_align: inputs ld_type, addr[1:0], rdata; output aligned 32-bit data. Unit-testable on its own.

Test Plan:
- Reset: rst=0 while mem_valid=1, mem_we=1, mem_rd=5 -> wb_we=0, wb_wdata=0. After release, the first posedge captures; wb_waddr=5.
- ALU write: wb_sel=00, alu_res=0x1234_5678, rd=3 -> next cycle wb_we=1, wb_waddr=3, wb_wdata=0x12345678. Same stimulus with rd=0 -> wb_we=0.
- Loads, rdata=0x80FF_7F01:
  - lb at offset 3 -> 0xFFFFFF80
  - lbu at offset 3 -> 0x00000080
  - lh at offset 2 -> 0xFFFF80FF
  - lhu at offset 0 -> 0x00007F01
  - lh at offset 1 -> 0x00007F01
  - lw -> 0x80FF7F01
- Link: wb_sel=10, pc=0x0040_0010 -> wdata=0x00400018. pc=0xFFFFFFFC -> 0x00000004.
- Stall/flush:
  - stall=1 for 3 cycles with changing inputs -> outputs frozen.
  - flush=1 with stall=1 -> wb_valid=0, wb_we=0 next cycle.
- CPU_RETIRE_CNT_EN defined: 10 valid instructions, 2 stalled cycles and 1 flush -> retire_cnt counts one per unstalled valid WB cycle. Preloading by running to 0xFFFFFFFF and then one more retirement -> retire_cnt wraps to 0. Undefined -> retire_cnt stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU pipeline: load types, write-back source
// selects and the link-address offset.
package cpu_pkg;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b010;
   localparam logic [2:0] LD_LH  = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   // Return address of a jump-and-link skips the delay slot.
   localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/cpu_load_align.sv
// Little-endian load alignment: picks the byte/halfword addressed by the low
// address bits and sign- or zero-extends it; unknown load types act as lw.
module cpu_load_align
   import cpu_pkg::*;
(
   input  logic [2:0]  ld_type,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      // addr[0] is deliberately ignored for halfword loads.
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

      data = rdata;
      case (ld_type)
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'b0, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'b0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/cpu_mem_wb_stage.sv
// MEM/WB pipeline register and write-back mux driving the register file port.
// Optional retired-instruction counter enabled by macro CPU_RETIRE_CNT_EN.
module cpu_mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW_RF = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_we,
   input  logic [4:0]       mem_rd,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_ld_type,
   input  logic [DW-1:0]    mem_alu_res,
   input  logic [DW-1:0]    mem_rdata,
   input  logic [DW-1:0]    mem_pc,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [AW_RF-1:0] wb_waddr,
   output logic [DW-1:0]    wb_wdata,
   output logic [31:0]      retire_cnt
);

   logic          valid_reg;
   logic          we_reg;
   logic [4:0]    rd_reg;
   logic [1:0]    wb_sel_reg;
   logic [2:0]    ld_type_reg;
   logic [DW-1:0] alu_res_reg;
   logic [DW-1:0] rdata_reg;
   logic [DW-1:0] pc_reg;
   logic [31:0]   ld_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg   <= 1'b0;
         we_reg      <= 1'b0;
         rd_reg      <= '0;
         wb_sel_reg  <= '0;
         ld_type_reg <= '0;
         alu_res_reg <= '0;
         rdata_reg   <= '0;
         pc_reg      <= '0;
      end else if (flush) begin
         // Bubble: only the qualifiers drop, payload is left as is.
         valid_reg <= 1'b0;
         we_reg    <= 1'b0;
      end else if (!stall) begin
         valid_reg   <= mem_valid;
         we_reg      <= mem_we;
         rd_reg      <= mem_rd;
         wb_sel_reg  <= mem_wb_sel;
         ld_type_reg <= mem_ld_type;
         alu_res_reg <= mem_alu_res;
         rdata_reg   <= mem_rdata;
         pc_reg      <= mem_pc;
      end
   end

   cpu_load_align u_load_align (
      .ld_type (ld_type_reg),
      .addr    (alu_res_reg[1:0]),
      .rdata   (rdata_reg[31:0]),
      .data    (ld_data)
   );

   always_comb begin
      wb_valid = valid_reg;
      wb_we    = valid_reg & we_reg & (rd_reg != 5'd0);
      wb_waddr = {{(AW_RF-5){1'b0}}, rd_reg};
      case (wb_sel_reg)
         WB_SEL_LOAD: wb_wdata = DW'(ld_data);
         WB_SEL_LINK: wb_wdata = pc_reg + DW'(LINK_OFFSET);
         default:     wb_wdata = alu_res_reg;
      endcase
   end

`ifdef CPU_RETIRE_CNT_EN
   logic [31:0] retire_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         retire_cnt_reg <= '0;
      else if (valid_reg && !stall)
         retire_cnt_reg <= retire_cnt_reg + 32'd1;
   end

   assign retire_cnt = retire_cnt_reg;
`else
   assign retire_cnt = '0;
`endif

endmodule
